apb_rr_master: RTL
==================

# apb_rr_master

Two-requester APB master that shares one APB bus between two command sources (e.g. a CPU-side port and a DMA/config sequencer) using round-robin arbitration. It accepts a command through a valid/ready handshake and runs the APB SETUP/ACCESS sequence, decoding the slave from the address MSB. It waits on PREADY, with an optional timeout, and returns read data or error to the winning requester. It sits between the requesters and the APB interconnect that feeds the two slaves.

## Interface
- ADDWIDTH, 8: slave-local address width; requester address is ADDWIDTH+1 bits, MSB selects the slave.
- DATAWIDTH, 32: data width; strobe width is DATAWIDTH/8.
- TIMEOUT, 15: maximum ACCESS wait cycles with PREADY low before abort; 0 disables; legal range 0..255.

- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- req_valid  in  2  bit i: requester i presents a command.
- req_ready  out  2  bit i: command i accepted this cycle (combinational).
- req_write  in  2  bit i: 1 = write, 0 = read.
- req_addr  in  2*(ADDWIDTH+1)  requester i address at slice i.
- req_wdata  in  2*DATAWIDTH  requester i write data at slice i.
- req_strb  in  2*(DATAWIDTH/8)  requester i byte strobes at slice i.
- rsp_valid  out  2  bit i: one-cycle completion pulse to requester i.
- rsp_rdata  out  DATAWIDTH  read data; valid with rsp_valid.
- rsp_err  out  1  PSLVERR or timeout; valid with rsp_valid.
- PSEL  out  2  slave selects.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDWIDTH  slave-local address.
- PWDATA  out  DATAWIDTH  write data.
- PSTRB  out  DATAWIDTH/8  write strobes; 0 on reads.
- PREADY  in  1  muxed ready from the selected slave.
- PRDATA  in  DATAWIDTH  muxed read data.
- PSLVERR  in  1  muxed slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: the grant is computed from the current req_valid. req_ready[g] = (state==IDLE) & req_valid[g] & grant[g] & !PRESET. At most one ready bit is high.
- Round-robin arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - The pointer updates only on acceptance.
- On acceptance, the following are latched:
  - owner.
  - PWRITE.
  - PADDR = addr[ADDWIDTH-1:0].
  - PSEL = one-hot of addr[ADDWIDTH] (0 selects PSEL[0], 1 selects PSEL[1]).
  - PWDATA.
  - PSTRB (forced to 0 when the command is a read).
  - Next state: SETUP.
- SETUP: PSEL held, PENABLE = 0. Next state: ACCESS; wait counter cleared.
- ACCESS: PENABLE = 1.
  - PREADY = 1: transfer completes and state goes to IDLE.
  - PREADY = 0 and TIMEOUT != 0 and wait count == TIMEOUT: transfer aborts and state goes to IDLE.
  - Otherwise the wait count increments (8-bit, saturating).
- On completion or abort (registered, visible the cycle state is IDLE):
  - PSEL = 0, PENABLE = 0.
  - rsp_valid[owner] = 1 for exactly one cycle.
  - rsp_rdata = PRDATA on a completed read; 0 on a write or abort.
  - rsp_err = PSLVERR on completion; 1 on abort.
- PADDR/PWRITE/PWDATA/PSTRB retain their last values after a transfer. rsp_rdata/rsp_err hold until the next rsp_valid.
- A requester may drop req_valid before acceptance without side effects. Fields must be stable while valid & !ready.
- No command queue: one outstanding transfer total.

## Timing
- Reset values:
  - PSEL 0, PENABLE 0, PWRITE 0, PADDR 0, PWDATA 0, PSTRB 0.
  - req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
  - state IDLE, last-grant 1, wait count 0.
- Acceptance at edge T (IDLE, valid & ready). T+1: SETUP (PSEL high). T+2: ACCESS (PENABLE high).
- PREADY sampled high at edge T+3 (zero-wait): cycle after T+3 is IDLE with rsp_valid high. A new command may be accepted in that same cycle.
- Zero-wait throughput: one transfer per 3 cycles. Each wait state adds 1 cycle.
- Timeout: abort at the ACCESS edge where the count equals TIMEOUT, i.e. after TIMEOUT+1 ACCESS cycles with PREADY low.
- PREADY high on the same edge as the timeout takes priority: completion, not error.
- PRESET asserted mid-transfer: all outputs return to reset values at the next edge. The transfer is dropped with no rsp_valid.

## Test plan
- Single write from requester 0, addr 0x000, wdata 0xCAFEBABE, strb 0xF, PREADY tied 1:
  - PSEL=01 one cycle with PENABLE=0, then one cycle with PENABLE=1.
  - rsp_valid=01, rsp_err=0, 3 cycles after acceptance.
- Requester 1 read addr 0x102, PREADY low for 2 ACCESS cycles then high, PRDATA 0xDEADCAFE:
  - PSEL=10, PADDR=0x02, PSTRB=0.
  - rsp_valid=10, rsp_rdata=0xDEADCAFE, 5 cycles after acceptance.
- Both requesters hold valid continuously for 4 transfers: grants alternate 0,1,0,1; each transfer 3 cycles apart with PREADY tied 1.
- PREADY stuck low, TIMEOUT=15:
  - Abort after 16 ACCESS cycles: rsp_err=1, rsp_rdata=0.
  - PSEL/PENABLE drop; next command is still serviced.
- PSLVERR=1 with PREADY on a write to 0x001, strb 0xA: PSTRB=0xA on the bus; rsp_err=1.
- PRESET pulsed during ACCESS: no rsp_valid; all outputs 0 next edge; first post-reset tie grants requester 0.

Source files
------------

// File: rtl/apb_rr_master.sv
// Two-requester APB master: round-robin arbitration between two command ports,
// APB SETUP/ACCESS sequencing with optional PREADY timeout, per-requester response pulse.
module apb_rr_master #(
    parameter int ADDWIDTH  = 8,
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 15
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [1:0]                     req_valid,
    output logic [1:0]                     req_ready,
    input  logic [1:0]                     req_write,
    input  logic [2*(ADDWIDTH+1)-1:0]      req_addr,
    input  logic [2*DATAWIDTH-1:0]         req_wdata,
    input  logic [2*(DATAWIDTH/8)-1:0]     req_strb,
    output logic [1:0]                     rsp_valid,
    output logic [DATAWIDTH-1:0]           rsp_rdata,
    output logic                           rsp_err,
    output logic [1:0]                     PSEL,
    output logic                           PENABLE,
    output logic                           PWRITE,
    output logic [ADDWIDTH-1:0]            PADDR,
    output logic [DATAWIDTH-1:0]           PWDATA,
    output logic [DATAWIDTH/8-1:0]         PSTRB,
    input  logic                           PREADY,
    input  logic [DATAWIDTH-1:0]           PRDATA,
    input  logic                           PSLVERR
);

    localparam int AW1 = ADDWIDTH + 1;
    localparam int SW  = DATAWIDTH / 8;
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t               state, state_nx;
    logic                 last_gnt;
    logic                 owner;
    logic [7:0]           wait_cnt;
    logic                 gsel;
    logic                 accept;
    logic                 done;
    logic                 abort;
    logic                 sel_write;
    logic [AW1-1:0]       sel_addr;
    logic [DATAWIDTH-1:0] sel_wdata;
    logic [SW-1:0]        sel_strb;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // On a tie the requester that did not win last time gets the bus.
    always_comb begin
        gsel      = (req_valid == 2'b11) ? ~last_gnt : req_valid[1];
        accept    = (state == IDLE) && (req_valid != 2'b00) && !PRESET;
        req_ready = {gsel, ~gsel} & {2{accept}};
        sel_write = gsel ? req_write[1] : req_write[0];
        sel_addr  = gsel ? req_addr[2*AW1-1:AW1] : req_addr[AW1-1:0];
        sel_wdata = gsel ? req_wdata[2*DATAWIDTH-1:DATAWIDTH] : req_wdata[DATAWIDTH-1:0];
        sel_strb  = gsel ? req_strb[2*SW-1:SW] : req_strb[SW-1:0];
        done      = (state == ACCESS) && PREADY;
        abort     = (state == ACCESS) && !PREADY && (TIMEOUT != 0) && (wait_cnt == TO_LIM);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (done || abort) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            last_gnt  <= 1'b1;
            owner     <= 1'b0;
            wait_cnt  <= 8'd0;
            PSEL      <= 2'b00;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            case (state)
                IDLE: if (accept) begin
                    owner    <= gsel;
                    last_gnt <= gsel;
                    PWRITE   <= sel_write;
                    PADDR    <= sel_addr[ADDWIDTH-1:0];
                    PSEL     <= sel_addr[ADDWIDTH] ? 2'b10 : 2'b01;
                    PWDATA   <= sel_wdata;
                    PSTRB    <= sel_write ? sel_strb : '0;
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= 8'd0;
                end
                ACCESS: if (done || abort) begin
                    // Response is registered so it lines up with the return to IDLE.
                    PSEL      <= 2'b00;
                    PENABLE   <= 1'b0;
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    rsp_rdata <= (done && !PWRITE) ? PRDATA : '0;
                    rsp_err   <= done ? PSLVERR : 1'b1;
                end else begin
                    wait_cnt <= sat_inc(wait_cnt);
                end
                default: ;
            endcase
        end
    end

endmodule
